sqrt_iter_ctrl: RTL and testbench

SQRT_ITER_CTRL -- requirements
Module: sqrt_iter_ctrl

---
 rtl/sqrt_pkg.sv | 20 ++
 rtl/sqrt_step.sv | 32 +++
 rtl/sqrt_iter_ctrl.sv | 99 +++++++++
 tb/tb_sqrt_iter_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// Shared types for the iterative square-root controller: FSM state encoding
// and the step-counter width helper.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned SQRT_DEF_WIDTH = 4;

  // Counter must hold WIDTH-1; never narrower than one bit.
  function automatic int unsigned step_cnt_w(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  localparam int unsigned STEP_W = step_cnt_w(SQRT_DEF_WIDTH);

endpackage

// File: rtl/sqrt_step.sv
// One digit-pair step of the restoring square root: shifts the next radicand
// pair into the partial remainder and tries subtracting {root, 01}.
module sqrt_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [2*WIDTH-1:0] rem,
  input  logic [WIDTH-1:0]   root,
  input  logic [1:0]         pair,
  output logic [WIDTH-1:0]   root_nxt,
  output logic [2*WIDTH-1:0] rem_nxt
);

  logic [2*WIDTH-1:0] target;
  logic [2*WIDTH-1:0] trial;
  logic               unused_rem_msbs;

  // The two top remainder bits are always zero at this point in the iteration.
  assign unused_rem_msbs = ^rem[2*WIDTH-1:2*WIDTH-2];

  always_comb begin
    target = {rem[2*WIDTH-3:0], pair};
    trial  = {{(WIDTH-2){1'b0}}, root, 2'b01};
    if (target >= trial) begin
      root_nxt = {root[WIDTH-2:0], 1'b1};
      rem_nxt  = target - trial;
    end else begin
      root_nxt = {root[WIDTH-2:0], 1'b0};
      rem_nxt  = target;
    end
  end

endmodule

// File: rtl/sqrt_iter_ctrl.sv
// Iterative integer square root, one root bit per cycle, valid/ready on both sides.
// Optional remainder output port enabled by defining SQRT_REM_OUT_EN.
module sqrt_iter_ctrl
  import sqrt_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] radicand,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   root,
`ifdef SQRT_REM_OUT_EN
  output logic [2*WIDTH-1:0] remainder,
`endif
  output logic               busy
);

  localparam int unsigned SW = step_cnt_w(WIDTH);
  localparam logic [SW-1:0] STEP_INIT = SW'(WIDTH-1);

  state_t             state_q, state_d;
  logic [SW-1:0]      step_q, step_d;
  logic [WIDTH-1:0]   root_q, root_d;
  logic [2*WIDTH-1:0] rem_q, rem_d;
  logic [2*WIDTH-1:0] rad_q, rad_d;

  logic [1:0]         pair;
  logic [WIDTH-1:0]   root_nxt;
  logic [2*WIDTH-1:0] rem_nxt;

  assign pair = 2'(rad_q >> {step_q, 1'b0});

  sqrt_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .root     (root_q),
    .pair     (pair),
    .root_nxt (root_nxt),
    .rem_nxt  (rem_nxt)
  );

  // Reset forces IDLE, so ready is additionally gated by rst_n to stay low in reset.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign root      = root_q;
`ifdef SQRT_REM_OUT_EN
  assign remainder = rem_q;
`endif

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    root_d  = root_q;
    rem_d   = rem_q;
    rad_d   = rad_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          rad_d   = radicand;
          root_d  = '0;
          rem_d   = '0;
          step_d  = STEP_INIT;
          state_d = CALC;
        end
      end
      CALC: begin
        root_d = root_nxt;
        rem_d  = rem_nxt;
        if (step_q == '0) state_d = DONE;
        else              step_d  = step_q - 1'b1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      rad_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      rad_q   <= rad_d;
    end
  end

endmodule

// File: tb/tb_sqrt_iter_ctrl.sv
// Scoreboard bench for sqrt_iter_ctrl: driver pushes expected results on accept,
// a negedge monitor checks latency, hold stability and values on every result.
module tb_sqrt_iter_ctrl;

  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*W-1:0] radicand = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   root;
  logic           busy;
`ifdef SQRT_REM_OUT_EN
  logic [2*W-1:0] remainder;
`endif

  typedef struct {
    logic [W-1:0]   root;
    logic [2*W-1:0] rem;
    int             acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   rdy_mode = 0;
  bit   ov_prev = 1'b0;

  sqrt_iter_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .radicand  (radicand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .root      (root),
`ifdef SQRT_REM_OUT_EN
    .remainder (remainder),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void ref_sqrt(input int r, output logic [W-1:0] q, output logic [2*W-1:0] m);
    q = '0;
    for (int i = 0; i < (1 << W); i++)
      if (i * i <= r) q = W'(i);
    m = (2*W)'(r - int'(q) * int'(q));
  endfunction

  // Monitor: compares on every DONE cycle, pops on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (busy) check("in_ready_when_busy", 32'(in_ready), 32'd0);
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          if (!ov_prev) check("latency", 32'(cyc - sb[0].acc), 32'(W));
          check("root", 32'(root), 32'(sb[0].root));
`ifdef SQRT_REM_OUT_EN
          check("remainder", 32'(remainder), 32'(sb[0].rem));
`endif
          if (out_ready) void'(sb.pop_front());
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic issue(input logic [2*W-1:0] r, input logic [W-1:0] er,
                       input logic [2*W-1:0] erem, input bit keep);
    int n = 0;
    radicand = r;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    sb.push_back('{root: er, rem: erem, acc: cyc + 1});
    last_acc = cyc + 1;
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
    radicand = ~r;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int a;
    logic [W-1:0]   q;
    logic [2*W-1:0] m;

    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_root", 32'(root), 32'd0);
`ifdef SQRT_REM_OUT_EN
    check("rst_remainder", 32'(remainder), 32'd0);
`endif
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    rdy_mode = 0;
    issue(8'd0,   4'd0,  8'd0,  1'b0);
    issue(8'd1,   4'd1,  8'd0,  1'b0);
    issue(8'd2,   4'd1,  8'd1,  1'b0);
    issue(8'd3,   4'd1,  8'd2,  1'b0);
    issue(8'd4,   4'd2,  8'd0,  1'b0);
    issue(8'd255, 4'd15, 8'd30, 1'b0);
    issue(8'd144, 4'd12, 8'd0,  1'b0);
    drain();

    // Consumer stalls for 10 cycles in DONE.
    rdy_mode = 1;
    issue(8'd50, 4'd7, 8'd1, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_out_valid", 32'(out_valid), 32'd1);
    repeat (10) @(negedge clk);
    rdy_mode = 0;
    n = 0;
    while (out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("release_busy", 32'(busy), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    issue(8'd16, 4'd4, 8'd0, 1'b1);
    a = last_acc;
    issue(8'd17, 4'd4, 8'd1, 1'b0);
    check("b2b_interval", 32'(last_acc - a), 32'd6);
    drain();

    // Reset in the second CALC cycle discards the operation.
    issue(8'd99, 4'd9, 8'd18, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_root", 32'(root), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
`ifdef SQRT_REM_OUT_EN
    check("midrst_remainder", 32'(remainder), 32'd0);
`endif
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_post_in_ready", 32'(in_ready), 32'd1);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    issue(8'd99, 4'd9, 8'd18, 1'b0);
    drain();

    rdy_mode = 2;
    for (int r = 0; r < 256; r++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      ref_sqrt(r, q, m);
      issue((2*W)'(r), q, m, 1'b0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
